// File: rtl/axi_rtc_event_stamp.sv
// Stamps rising edges of an asynchronous event against the RTC time, removes the
// synchronizer latency, and streams the stamps out of a FWFT FIFO on AXI4-Stream.
module axi_rtc_event_stamp #(
  parameter int unsigned CLOCK_FREQUENCY = 125000000,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [31:0]                   rtc_sec,
  input  logic [31:0]                   rtc_nsec,
  input  logic                          event_in,
  input  logic                          enable,
  input  logic                          clear_drop,
  output logic [63:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NS_PER_SEC  = 32'd1000000000;
  localparam logic [31:0] LATENCY_NS  = 32'(2 * (1000000000 / CLOCK_FREQUENCY));
  localparam logic [AW:0] FULL_LEVEL  = FIFO_DEPTH[AW:0];

  logic        s1_q, s2_q, s3_q;
  logic        raw_v_q, corr_v_q;
  logic [63:0] raw_q, corr_q, corr_d;
  logic        rise;

  logic [63:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, level;
  logic        full, write_ok, drop, pop;
  logic [15:0] drop_count_q;

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      raw_v_q  <= 1'b0;
      corr_v_q <= 1'b0;
    end else begin
      s1_q     <= event_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      raw_v_q  <= rise & enable;
      corr_v_q <= raw_v_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (rise & enable) begin
      raw_q <= {rtc_sec, rtc_nsec};
    end
    corr_q <= corr_d;
  end

  // Borrow a second when the raw nanoseconds are below the latency; sec wraps mod 2^32.
  always_comb begin
    corr_d = raw_q;
    if (raw_q[31:0] >= LATENCY_NS) begin
      corr_d[31:0] = raw_q[31:0] - LATENCY_NS;
    end else begin
      corr_d[31:0]  = raw_q[31:0] + NS_PER_SEC - LATENCY_NS;
      corr_d[63:32] = raw_q[63:32] - 32'd1;
    end
  end

  // Fullness is judged on the occupancy before this cycle's pop.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == FULL_LEVEL);
  assign write_ok = corr_v_q & ~full;
  assign drop     = corr_v_q & full;
  assign pop      = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge aclk) begin
    if (write_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= corr_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (write_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clear_drop) begin
      drop_count_q <= '0;
    end else if (drop && (drop_count_q != '1)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign m_axis_tvalid = (level != '0);
  assign m_axis_tdata  = mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_level    = level;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_axi_rtc_event_stamp.sv
// Randomized and directed bench for axi_rtc_event_stamp: a cycle-level reference
// model fills a scoreboard that a separate monitor drains on each AXI beat.
module tb_axi_rtc_event_stamp;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam longint unsigned LAT = 64'd16;
  localparam longint unsigned NSS = 64'd1000000000;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   rtc_sec = '0;
  logic [31:0]   rtc_nsec = '0;
  logic          event_in = 1'b0;
  logic          enable = 1'b1;
  logic          clear_drop = 1'b0;
  logic [63:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [LW-1:0] fifo_level;
  logic [15:0]   drop_count;

  always #5 aclk = ~aclk;

  axi_rtc_event_stamp #(
    .CLOCK_FREQUENCY(125000000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .rtc_sec(rtc_sec),
    .rtc_nsec(rtc_nsec),
    .event_in(event_in),
    .enable(enable),
    .clear_drop(clear_drop),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .fifo_level(fifo_level),
    .drop_count(drop_count)
  );

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Stamp = event time minus two clocks, on the absolute ns timeline modulo 2^32 seconds.
  function automatic logic [63:0] expect_stamp(logic [31:0] s, logic [31:0] ns);
    longint unsigned total;
    longint unsigned span;
    span  = 64'd4294967296 * NSS;
    total = {32'b0, s} * NSS + {32'b0, ns};
    if (total >= LAT) total = total - LAT;
    else              total = total + span - LAT;
    return {32'(total / NSS), 32'(total % NSS)};
  endfunction

  // RTC source: counting, held, or random per cycle
  int          rtc_mode = 0;
  logic [31:0] hold_sec = '0;
  logic [31:0] hold_nsec = '0;

  initial begin
    forever begin
      @(negedge aclk);
      case (rtc_mode)
        0: begin
          if (rtc_nsec >= 32'd999999992) begin
            rtc_nsec = rtc_nsec - 32'd999999992;
            rtc_sec  = rtc_sec + 32'd1;
          end else begin
            rtc_nsec = rtc_nsec + 32'd8;
          end
        end
        1: begin
          rtc_sec  = hold_sec;
          rtc_nsec = hold_nsec;
        end
        default: begin
          rtc_sec  = $urandom;
          rtc_nsec = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40)
                                                 : $urandom_range(0, 999999999);
        end
      endcase
    end
  end

  // Reference model
  typedef struct {
    int          due;
    logic [63:0] stamp;
  } pend_t;

  int          cyc = 0;
  bit          last_ev = 1'b0;
  int          e0_q[$];
  pend_t       pend_q[$];
  logic [63:0] model_q[$];
  logic [63:0] sb_q[$];
  int          model_drop = 0;

  initial begin
    pend_t p;
    bit    do_pop;
    forever begin
      @(posedge aclk);
      cyc++;
      if (!aresetn) begin
        last_ev = 1'b0;
        e0_q.delete();
        pend_q.delete();
        model_q.delete();
        sb_q.delete();
        model_drop = 0;
      end else begin
        if (e0_q.size() > 0 && e0_q[0] + 2 == cyc) begin
          void'(e0_q.pop_front());
          if (enable) pend_q.push_back('{cyc + 2, expect_stamp(rtc_sec, rtc_nsec)});
        end
        if (event_in && !last_ev) e0_q.push_back(cyc);
        last_ev = event_in;
        do_pop = (model_q.size() != 0) && m_axis_tready;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          p = pend_q.pop_front();
          if (model_q.size() < DEPTH) begin
            model_q.push_back(p.stamp);
            sb_q.push_back(p.stamp);
          end else if (model_drop < 65535) begin
            model_drop++;
          end
        end
        if (clear_drop) model_drop = 0;
        if (do_pop) void'(model_q.pop_front());
      end
    end
  end

  // Monitor: one sample per cycle, after the driver has settled its inputs
  initial begin
    bit          stall = 1'b0;
    logic [63:0] held = '0;
    forever begin
      @(negedge aclk);
      #1;
      check("tvalid", {63'b0, m_axis_tvalid}, {63'b0, model_q.size() != 0});
      check("fifo_level", 64'(fifo_level), 64'(model_q.size()));
      check("drop_count", 64'(drop_count), 64'(model_drop));
      if (stall) begin
        check("stall_tvalid", {63'b0, m_axis_tvalid}, 64'd1);
        check("stall_tdata", m_axis_tdata, held);
      end
      if (m_axis_tvalid && m_axis_tready && aresetn) begin
        if (sb_q.size() == 0) check("beat_unexpected", m_axis_tdata, 64'hx);
        else check("beat", m_axis_tdata, sb_q.pop_front());
      end
      stall = m_axis_tvalid && !m_axis_tready && aresetn;
      held  = m_axis_tdata;
    end
  end

  task automatic pulse(int hi, int lo);
    event_in = 1'b1;
    repeat (hi) @(negedge aclk);
    event_in = 1'b0;
    repeat (lo) @(negedge aclk);
  endtask

  // Single-cycle pulse; returns just after E4 with tready/clear_drop applied at E4.
  task automatic edge_to_e4(bit rdy, bit clr);
    event_in = 1'b1;
    @(negedge aclk);
    event_in = 1'b0;
    repeat (3) @(negedge aclk);
    m_axis_tready = rdy;
    clear_drop    = clr;
    @(negedge aclk);
    clear_drop = 1'b0;
    #1;
  endtask

  task automatic drain();
    m_axis_tready = 1'b1;
    repeat (10) @(negedge aclk);
  endtask

  initial begin
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_tvalid", {63'b0, m_axis_tvalid}, 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Basic stamp and latency, RTC counting; hold tready low so the beat stays visible
    m_axis_tready = 1'b0;
    edge_to_e4(1'b0, 1'b0);
    check("lat_tvalid_e4", {63'b0, m_axis_tvalid}, 64'd1);
    drain();
    event_in = 1'b1;
    @(negedge aclk);
    event_in = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check("lat_tvalid_e3", {63'b0, m_axis_tvalid}, 64'd0);
    repeat (6) @(negedge aclk);

    // Borrow cases with held RTC
    rtc_mode = 1; hold_sec = 32'd7; hold_nsec = 32'd8;
    repeat (2) @(negedge aclk);
    edge_to_e4(1'b0, 1'b0);
    check("borrow_7_8", m_axis_tdata, {32'd6, 32'd999999992});
    drain();
    hold_sec = 32'd0; hold_nsec = 32'd0;
    repeat (2) @(negedge aclk);
    edge_to_e4(1'b0, 1'b0);
    check("borrow_0_0", m_axis_tdata, {32'hFFFFFFFF, 32'd999999984});
    drain();
    rtc_mode = 0;

    // Overflow: 6 edges into a depth-4 FIFO with no ready
    clear_drop = 1'b1;
    @(negedge aclk);
    clear_drop = 1'b0;
    m_axis_tready = 1'b0;
    repeat (6) pulse(1, 3);
    repeat (8) @(negedge aclk);
    #1;
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_drop", 64'(drop_count), 64'd2);
    drain();
    check("ovf_empty", {63'b0, m_axis_tvalid}, 64'd0);

    // Full FIFO with concurrent pop, then clear_drop against a drop
    clear_drop = 1'b1;
    @(negedge aclk);
    clear_drop = 1'b0;
    m_axis_tready = 1'b0;
    repeat (4) pulse(1, 3);
    repeat (6) @(negedge aclk);
    edge_to_e4(1'b1, 1'b0);
    m_axis_tready = 1'b0;
    check("fullpop_level", 64'(fifo_level), 64'd3);
    check("fullpop_drop", 64'(drop_count), 64'd1);
    pulse(1, 3);
    repeat (4) @(negedge aclk);
    edge_to_e4(1'b0, 1'b1);
    check("clr_vs_drop", 64'(drop_count), 64'd0);
    check("clr_level", 64'(fifo_level), 64'd4);
    drain();

    // Enable low, long level, backpressure burst
    enable = 1'b0;
    pulse(1, 8);
    enable = 1'b1;
    #1;
    check("en0_nobeat", {63'b0, m_axis_tvalid}, 64'd0);
    m_axis_tready = 1'b0;
    pulse(100, 8);
    #1;
    check("level_one_stamp", 64'(fifo_level), 64'd1);
    drain();
    fork
      repeat (3) pulse(1, 2);
      for (int i = 0; i < 30; i++) begin
        m_axis_tready = i[0];
        @(negedge aclk);
      end
    join
    drain();

    // Reset at E3 of an event
    event_in = 1'b1;
    @(negedge aclk);
    event_in = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (6) @(negedge aclk);
    #1;
    check("rstmid_tvalid", {63'b0, m_axis_tvalid}, 64'd0);
    check("rstmid_level", 64'(fifo_level), 64'd0);
    check("rstmid_drop", 64'(drop_count), 64'd0);
    m_axis_tready = 1'b0;
    edge_to_e4(1'b0, 1'b0);
    check("rstmid_next", {63'b0, m_axis_tvalid}, 64'd1);
    drain();

    // Randomized traffic with random RTC, ready, enable, clears and resets
    rtc_mode = 2;
    for (int n = 0; n < 400; n++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      enable        = ($urandom_range(0, 7) != 0);
      clear_drop    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) begin
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
      end
      pulse($urandom_range(1, 4), $urandom_range(2, 6));
    end
    clear_drop = 1'b0;
    enable     = 1'b1;
    m_axis_tready = 1'b1;
    for (int w = 0; w < 50 && (model_q.size() != 0 || pend_q.size() != 0); w++) begin
      @(negedge aclk);
    end
    repeat (2) @(negedge aclk);
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
